// File: rtl/key_frame_loader_if.sv
// rtl/key_frame_loader_if.sv - bit-serial key beat handshake (valid/ready)
interface key_frame_loader_if;
  logic s_valid;
  logic s_data;
  logic s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/key_frame_loader.sv
// rtl/key_frame_loader.sv - serial key frame receiver with even-parity check and atomic key apply
module key_frame_loader #(
  parameter int KEY_WIDTH = 64,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 PRESET,
  input  logic                 clear,
  key_frame_loader_if.slave    s,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 key_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);
  localparam logic [CNT_W-1:0] KW_C = CNT_W'(KEY_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t               state;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CNT_W-1:0]     cnt;
  logic                 parity;
  logic                 par_ok;
  logic                 beat;

  assign beat = s.s_valid && s.s_ready;

  always_ff @(posedge CLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      parity    <= 1'b0;
      par_ok    <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      err_cnt   <= '0;
      s.s_ready <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      // Abort everything except the bad-frame history.
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      parity    <= 1'b0;
      par_ok    <= 1'b0;
      key_out   <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      s.s_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s.s_ready <= 1'b1;
          busy      <= 1'b0;
          if (beat) begin
            shadow <= {shadow[KEY_WIDTH-2:0], s.s_data};
            parity <= s.s_data;
            cnt    <= CNT_W'(1);
            state  <= SHIFT;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          s.s_ready <= 1'b1;
          busy      <= 1'b1;
          if (beat) begin
            if (cnt < KW_C) begin
              shadow <= {shadow[KEY_WIDTH-2:0], s.s_data};
              parity <= parity ^ s.s_data;
              cnt    <= cnt + CNT_W'(1);
            end else begin
              // This beat is the parity bit; hold off the source for the apply cycle.
              par_ok    <= ~(parity ^ s.s_data);
              state     <= CHECK;
              s.s_ready <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (par_ok) begin
            key_out   <= shadow;
            key_valid <= 1'b1;
            key_err   <= 1'b0;
          end else begin
            key_out   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
          shadow    <= '0;
          cnt       <= '0;
          parity    <= 1'b0;
          par_ok    <= 1'b0;
          state     <= IDLE;
          s.s_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          s.s_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
